// File: rtl/timer_pkg.sv
// Shared constants for the timer counting core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

    localparam int CNT_W_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // Index into clk_in selecting the divided clock.
    typedef enum logic [1:0] {
        CKS_DIV2  = 2'd0,
        CKS_DIV4  = 2'd1,
        CKS_DIV8  = 2'd2,
        CKS_DIV16 = 2'd3
    } cks_e;

endpackage

// File: rtl/timer_edge_sync.sv
// Synchronizes one divided-clock bit into pclk and flags its rising edge.
// Latency: rise_o is high SYNC_STAGES cycles after d_i is first sampled high.
// Backpressure: none; free-running, one-cycle rise_o pulse per 0->1 of d_i.
//
// Ports: pclk/preset clock and async active-high reset; d_i raw input bit;
//        rise_o one-cycle pulse on a synchronized rising edge.
module timer_edge_sync
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic pclk,
    input  logic preset,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/timer_cnt_core.sv
// 8-bit timer counter: selects a synchronized divided clock, counts its edges up/down with load.
// Latency: clk_in edge -> cnt update SYNC_STAGES+1 cycles; load -> cnt next cycle.
// Backpressure: none; control inputs are sampled every cycle.
//
// Ports: pclk/preset clock and async active-high reset; clk_in[3:0] divided clocks
//        (/2,/4,/8,/16); cks clock select; en count enable; dwn_up direction (1=down);
//        load/tdr synchronous load; cnt count; ovf_pulse/udf_pulse one-cycle wrap flags.
//        With TIMER_CMP_EN defined: cmp compare value, cmp_match one-cycle match pulse.
module timer_cnt_core
    import timer_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic [3:0]       clk_in,
    input  logic [1:0]       cks,
    input  logic             en,
    input  logic             dwn_up,
    input  logic             load,
    input  logic [CNT_W-1:0] tdr,
`ifdef TIMER_CMP_EN
    input  logic [CNT_W-1:0] cmp,
    output logic             cmp_match,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic             ovf_pulse,
    output logic             udf_pulse
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       rise;
    logic [1:0]       cks_q;
    logic             tick;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    for (genvar i = 0; i < 4; i++) begin : g_sync
        timer_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .pclk  (pclk),
            .preset(preset),
            .d_i   (clk_in[i]),
            .rise_o(rise[i])
        );
    end

    // A rise seen in the cycle cks changes may belong to the old clock's
    // history; drop it so a switch never produces a spurious count.
    assign tick = rise[cks] & (cks == cks_q);

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        if (load) begin
            cnt_d = tdr;
        end else if (en && tick) begin
            if (!dwn_up) begin
                cnt_d = cnt_q + ONE;
                ovf_d = (cnt_q == '1);
            end else begin
                cnt_d = cnt_q - ONE;
                udf_d = (cnt_q == '0);
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cks_q <= CKS_DIV2;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            cks_q <= cks;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign cnt       = cnt_q;
    assign ovf_pulse = ovf_q;
    assign udf_pulse = udf_q;

`ifdef TIMER_CMP_EN
    logic cmp_q, cmp_d;

    // Only a fresh write (load or counted tick) can match; holding does not re-pulse.
    assign cmp_d = (load | (en & tick)) & (cnt_d == cmp);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cmp_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
        end
    end

    assign cmp_match = cmp_q;
`endif

endmodule
